// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 valid/ready stream mux, fixed-select or round-robin, registered output.
// Define STREAM_MUX_LAST_EN to add in_last/out_last and hold a grant until the packet's last word.
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int CH    = 4,
  localparam int SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
`ifdef STREAM_MUX_LAST_EN
  input  logic [CH-1:0]       in_last,
  output logic                out_last,
`endif
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_ch,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;
  logic             load_en;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  idx;
  logic [CH-1:0]    grant;
  logic             xfer;
  logic             gnt_last;
  logic [WIDTH-1:0] gnt_data;

`ifdef STREAM_MUX_LAST_EN
  logic             lock;
  logic [SELW-1:0]  locked_ch;
`endif

  assign load_en = !out_valid || out_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (!mode) begin
      if ((int'(sel) < CH) && in_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      // Walk offsets downward so the nearest valid channel after ptr wins last.
      for (int k = CH - 1; k >= 0; k--) begin
        idx = SELW'((int'(ptr) + k) % CH);
        if (in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
      end
    end
`ifdef STREAM_MUX_LAST_EN
    if (lock) begin
      gnt_any = in_valid[locked_ch];
      gnt_idx = locked_ch;
    end
`endif
  end

  assign grant    = gnt_any ? ({{(CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign xfer     = gnt_any && load_en;
  assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign ptr_next = (gnt_idx == SELW'(CH - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef STREAM_MUX_LAST_EN
  assign gnt_last = in_last[gnt_idx];
`else
  assign gnt_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pointer only moves at packet boundaries, and only under round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && mode && gnt_last) begin
      ptr <= ptr_next;
    end
  end

`ifdef STREAM_MUX_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last  <= 1'b0;
      lock      <= 1'b0;
      locked_ch <= '0;
    end else if (xfer) begin
      out_last  <= gnt_last;
      lock      <= !gnt_last;
      locked_ch <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a behavioural model.
module tb_stream_mux_rr;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef STREAM_MUX_LAST_EN
  logic [3:0]  in_last;
  logic        out_last;
  logic [2:0]  in_last3;
  logic        out_last3;
`endif

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit        m_valid;
  bit [7:0]  m_data;
  int        m_ch;
  bit        m_last;
  int        m_ptr;
  bit        m_lock;
  int        m_lch;
  logic [3:0] last_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LAST_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef STREAM_MUX_LAST_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closest valid channel at or after ptr (circular distance); lock and fixed select take priority.
  function automatic int model_grant();
    int best, bestd, d;
    best  = -1;
    bestd = CH;
    if (m_lock) return in_valid[m_lch] ? m_lch : -1;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < CH; i++) begin
      d = (i - m_ptr + CH) % CH;
      if (in_valid[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_ch = 0; m_last = 0; m_ptr = 0; m_lock = 0; m_lch = 0;
  endtask

  task automatic step();
    int g;
    bit le, lastb;
    logic [3:0] er;
    #1;
    g  = model_grant();
    le = !m_valid || out_ready;
    er = (le && g >= 0) ? (4'b0001 << g) : 4'b0000;
    last_ready = in_ready;
    check("in_ready", {28'd0, in_ready}, {28'd0, er});
    @(posedge clk);
    lastb = 1'b1;
`ifdef STREAM_MUX_LAST_EN
    if (g >= 0) lastb = in_last[g];
`endif
    if (le && g >= 0) begin
      m_valid = 1;
      m_data  = in_data[g*8 +: 8];
      m_ch    = g;
      m_last  = lastb;
      if (mode && lastb) m_ptr = (g + 1) % CH;
`ifdef STREAM_MUX_LAST_EN
      m_lock = !lastb;
      m_lch  = g;
`endif
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data", {24'd0, out_data}, {24'd0, m_data});
    check("out_ch", {30'd0, out_ch}, m_ch);
`ifdef STREAM_MUX_LAST_EN
    check("out_last", {31'd0, out_last}, {31'd0, m_last});
`endif
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 32'h13121110;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h323130; in_valid3 = 3'b000; out_ready3 = 1'b1;
`ifdef STREAM_MUX_LAST_EN
    in_last = 4'hF; in_last3 = 3'h7;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_ch", {30'd0, out_ch}, 32'd0);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    rst_n = 1'b1;

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000;
    step();
    check("t1_in_ready", {28'd0, last_ready}, 32'h4);
    check("t1_data", {24'd0, out_data}, 32'hA5);
    check("t1_ch", {30'd0, out_ch}, 32'd2);
    in_valid = 4'b0000;
    step();

    // Round-robin, all valid: 0,1,2,3,0 back to back
    mode = 1'b1; in_valid = 4'hF; in_data = 32'h13121110;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq_ch", {30'd0, out_ch}, i % 4);
      check("rr_seq_valid", {31'd0, out_valid}, 32'd1);
      check("rr_seq_data", {24'd0, out_data}, 32'h10 + (i % 4));
    end

    // Move ptr to 3, then wrap to channel 0 and follow with channel 1
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0011;
    step();
    check("wrap_ch0", {30'd0, out_ch}, 32'd0);
    step();
    check("wrap_ch1", {30'd0, out_ch}, 32'd1);

    // Stall for three cycles, then drain and load in one cycle
    out_ready = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", {28'd0, last_ready}, 32'd0);
      check("stall_data", {24'd0, out_data}, 32'h11);
      check("stall_ch", {30'd0, out_ch}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("drain_load_ch", {30'd0, out_ch}, 32'd2);
    check("drain_load_valid", {31'd0, out_valid}, 32'd1);

    // Reach ptr=2 with a word held, then pulse reset between edges
    in_valid = 4'b0010;
    step();
    in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_out_ch", {30'd0, out_ch}, 32'd0);
    check("arst_in_ready", {28'd0, in_ready}, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step();
    check("arst_ptr0", {30'd0, out_ch}, 32'd0);

`ifdef STREAM_MUX_LAST_EN
    // Packet of three words from ch1 holds the grant against ch0/ch2
    in_valid = 4'b0111; in_data = 32'h13121110;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 0 || i == 1) ? 4'b1101 : 4'hF;
      step();
      check("lock_ch", {30'd0, out_ch}, (i < 3) ? 32'd1 : 32'd2);
    end
    in_last = 4'hF;
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LAST_EN
      in_last   = 4'($urandom);
`endif
      step();
    end
    in_valid = 4'h0;

    // Three-channel instance: out-of-range select and wrap from CH-1
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    check("ch3_sel_oob", {29'd0, in_ready3}, 32'd0);
    sel3 = 2'd2;
    #1;
    check("ch3_sel2", {29'd0, in_ready3}, 32'h4);
    mode3 = 1'b1;
    #1;
    check("ch3_rr_first", {29'd0, in_ready3}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("ch3_rr_ch", {30'd0, out_ch3}, i % 3);
      check("ch3_rr_data", {24'd0, out_data3}, 32'h30 + (i % 3));
    end
    in_valid3 = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
